// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//   Round-robin arbiter that serialises the M-stage data-memory accesses of
//   NUM_CORES cores onto one req/ack memory port.
//
//   Optional feature macro: MEM_ARB_TIMEOUT_EN
//     When it is defined, an ack watchdog aborts an access after TIMEOUT BUSY
//     cycles and raises a sticky err output. When it is undefined, there is no
//     err port and BUSY waits for mem_ack indefinitely.
//
// Ports
//   clk        in   clock; all state changes on posedge
//   reset      in   asynchronous active-low reset
//   enable_M   in   2 bits per core: 01=LD, 10=ST, 00/11=idle
//   addr_M     in   ADDR_W bits per core, access address
//   wr_data_M  in   DATA_W bits per core, store data
//   ready_M    out  one bit per core, single-cycle completion pulse
//   rd_data_M  out  load data, shared by all cores
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  1=write, 0=read
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_ack    in   memory done, may arrive in mem_req's first cycle
//   mem_rdata  in   read data, valid with mem_ack
//   err        out  sticky timeout flag (MEM_ARB_TIMEOUT_EN only)
module core_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2*NUM_CORES-1:0]      enable_M,
  input  logic [ADDR_W*NUM_CORES-1:0] addr_M,
  input  logic [DATA_W*NUM_CORES-1:0] wr_data_M,
  output logic [NUM_CORES-1:0]        ready_M,
  output logic [DATA_W-1:0]           rd_data_M,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                        err
`endif
);

  localparam int GW = $clog2(NUM_CORES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (NUM_CORES < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("core_mem_arbiter: NUM_CORES and TIMEOUT must both be at least 2");
  end

  logic [1:0]        r_state;
  logic [GW-1:0]     r_last;
  logic [GW-1:0]     r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd;

  logic [NUM_CORES-1:0] w_valid;
  logic [NUM_CORES-1:0] w_st;
  logic [ADDR_W-1:0]    w_addr  [NUM_CORES];
  logic [DATA_W-1:0]    w_wdata [NUM_CORES];

  // Only 01 and 10 are real requests; 11 is treated as idle.
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    assign w_valid[c] = enable_M[2*c] ^ enable_M[2*c+1];
    assign w_st[c]    = enable_M[2*c+1];
    assign w_addr[c]  = addr_M[c*ADDR_W +: ADDR_W];
    assign w_wdata[c] = wr_data_M[c*DATA_W +: DATA_W];
  end

  // Scan cores starting just after the last grant; the first valid one wins.
  logic          w_any;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_cand;

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      w_cand = GW'((32'(r_last) + i) % 32'(NUM_CORES));
      if (!w_any && w_valid[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TOW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  logic [TOW-1:0] r_cnt;
  logic           r_err;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= GW'(NUM_CORES - 1);
      r_grant <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_we    <= w_st[w_pick];
            r_addr  <= w_addr[w_pick];
            r_wdata <= w_wdata[w_pick];
            r_state <= S_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
          // An ack on the final watchdog cycle still completes normally.
          if (mem_ack) begin
            if (!r_we) begin
              r_rd <= mem_rdata;
            end
            r_state <= S_DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            r_rd    <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = (r_state == S_BUSY);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rd_data_M = r_rd;
  assign ready_M   = (r_state == S_DONE) ? (NUM_CORES'(1) << r_grant) : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err = r_err;
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter
//   Self-checking bench for core_mem_arbiter: directed scenarios plus a
//   randomized run against a transaction-timeline reference model.
//   Honours MEM_ARB_TIMEOUT_EN (DUT built with TIMEOUT=8).
module tb_core_mem_arbiter;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 10;

  logic              clk;
  logic              reset;
  logic [2*NC-1:0]   enable_M;
  logic [AW*NC-1:0]  addr_M;
  logic [DW*NC-1:0]  wr_data_M;
  logic [NC-1:0]     ready_M;
  logic [DW-1:0]     rd_data_M;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ack;
  logic [DW-1:0]     mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic              err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Memory responder controls
  bit          resp_rand;
  bit          resp_hold;
  bit          resp_busy;
  int          resp_delay;
  int          resp_wait;
  logic [DW-1:0] resp_data;

  core_mem_arbiter #(
    .NUM_CORES (NC),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable_M  (enable_M),
    .addr_M    (addr_M),
    .wr_data_M (wr_data_M),
    .ready_M   (ready_M),
    .rd_data_M (rd_data_M),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_core(input int c, input logic [1:0] code,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    enable_M[2*c +: 2]   = code;
    addr_M[c*AW +: AW]   = a;
    wr_data_M[c*DW +: DW] = d;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  // The memory responder acks after resp_wait cycles of mem_req.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset) begin
      mem_ack   = 1'b0;
      resp_busy = 1'b0;
    end else if (mem_ack) begin
      mem_ack   = 1'b0;
      resp_busy = 1'b0;
    end else if (mem_req && !resp_hold) begin
      if (!resp_busy) begin
        resp_busy = 1'b1;
        resp_wait = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
      end
      if (resp_wait == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = resp_rand ? DW'($urandom) : resp_data;
      end else begin
        resp_wait--;
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    enable_M   = '0;
    addr_M     = '0;
    wr_data_M  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    resp_busy  = 1'b0;
    resp_hold  = 1'b0;
    resp_rand  = 1'b0;
    resp_delay = 0;
    resp_wait  = 0;
    resp_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ack = 1'b0;
    set_core(1, 2'b01, 10'h155, 8'hAA);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr); end
    vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h expected 00", mem_wdata); end
    vectors++; if (ready_M !== '0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", ready_M); end
    vectors++; if (rd_data_M !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 00", rd_data_M); end
`ifdef MEM_ARB_TIMEOUT_EN
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
  endtask

  // Single load from core 0, ack in mem_req's first cycle.
  task automatic test_single_load();
    do_reset();
    resp_data = 8'h3C;
    set_core(0, 2'b01, 10'h005, 8'h00);
    tick(); @(negedge clk);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ld_req: got %b expected 1", mem_req); end
    vectors++; if (mem_addr !== 10'h005) begin miscompares++; $display("FAIL ld_addr: got %h expected 005", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL ld_we: got %b expected 0", mem_we); end
    vectors++; if (ready_M !== 4'b0000) begin miscompares++; $display("FAIL ld_ready_busy: got %b expected 0000", ready_M); end
    tick(); @(negedge clk);
    vectors++; if (ready_M !== 4'b0001) begin miscompares++; $display("FAIL ld_ready: got %b expected 0001", ready_M); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL ld_req_done: got %b expected 0", mem_req); end
    vectors++; if (rd_data_M !== 8'h3C) begin miscompares++; $display("FAIL ld_rdata: got %h expected 3c", rd_data_M); end
    tick(); set_core(0, 2'b00, '0, '0); @(negedge clk);
    vectors++; if (ready_M !== 4'b0000) begin miscompares++; $display("FAIL ld_ready_after: got %b expected 0000", ready_M); end
    tick(); @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL ld_no_reissue: got %b expected 0", mem_req); end
    vectors++; if (rd_data_M !== 8'h3C) begin miscompares++; $display("FAIL ld_rdata_hold: got %h expected 3c", rd_data_M); end
  endtask

  // All four cores store at once; service order 0,1,2,3, three cycles apart.
  task automatic test_all_store();
    int k;
    int last_rdy;
    int served;
    logic [AW-1:0] ea;
    logic [NC-1:0] er;
    do_reset();
    for (int c = 0; c < NC; c++) set_core(c, 2'b10, AW'(c*256 + 'hA0 + c), DW'('h10 + c));
    k = 0; last_rdy = -1; served = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (served >= 0) begin set_core(served, 2'b00, '0, '0); served = -1; end
      @(negedge clk);
      if (mem_req && k < NC) begin
        ea = AW'(k*256 + 'hA0 + k);
        vectors++; if (mem_addr !== ea) begin miscompares++; $display("FAIL st_addr: got %h expected %h", mem_addr, ea); end
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL st_we: got %b expected 1", mem_we); end
        vectors++; if (mem_wdata !== DW'('h10 + k)) begin miscompares++; $display("FAIL st_wdata: got %h expected %h", mem_wdata, DW'('h10 + k)); end
      end
      if (ready_M !== '0 && k < NC) begin
        er = NC'(1) << k;
        vectors++; if (ready_M !== er) begin miscompares++; $display("FAIL st_ready: got %b expected %b", ready_M, er); end
        if (k > 0) begin
          vectors++; if (cyc - last_rdy !== 3) begin miscompares++; $display("FAIL st_spacing: got %0d expected 3", cyc - last_rdy); end
        end
        last_rdy = cyc; served = k; k++;
      end
    end
    vectors++; if (k !== NC) begin miscompares++; $display("FAIL st_count: got %0d expected %0d", k, NC); end
  endtask

  // Cores 1 and 3 request continuously: grants alternate 1,3,1,3...
  task automatic test_alternate();
    int k;
    bit prev_req;
    logic [1:0] gid;
    logic [1:0] eg;
    logic [NC-1:0] er;
    do_reset();
    set_core(1, 2'b01, 10'h131, 8'h00);
    set_core(3, 2'b01, 10'h333, 8'h00);
    k = 0; prev_req = 1'b0; gid = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick(); @(negedge clk);
      if (mem_req && !prev_req) begin
        gid = mem_addr[AW-1:AW-2];
        eg = (k % 2 == 0) ? 2'd1 : 2'd3;
        vectors++; if (gid !== eg) begin miscompares++; $display("FAIL alt_grant: got %0d expected %0d", gid, eg); end
        k++;
      end
      if (ready_M !== '0) begin
        er = NC'(1) << gid;
        vectors++; if (ready_M !== er) begin miscompares++; $display("FAIL alt_ready: got %b expected %b", ready_M, er); end
      end
      prev_req = mem_req;
    end
    vectors++; if (k < 12) begin miscompares++; $display("FAIL alt_count: got %0d expected >=12", k); end
  endtask

  // Core 2 load with a slow ack; core 0 drives the illegal 11 code.
  task automatic test_delayed_ack();
    int req_cycles;
    int rdy_cnt;
    int served;
    do_reset();
    resp_delay = 5;
    resp_data  = 8'hA7;
    set_core(0, 2'b11, 10'h011, 8'h55);
    set_core(2, 2'b01, 10'h277, 8'h00);
    req_cycles = 0; rdy_cnt = 0; served = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (served >= 0) begin set_core(served, 2'b00, '0, '0); served = -1; end
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        vectors++; if (mem_addr !== 10'h277) begin miscompares++; $display("FAIL dly_addr: got %h expected 277", mem_addr); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL dly_we: got %b expected 0", mem_we); end
      end
      if (ready_M !== '0) begin
        rdy_cnt++;
        vectors++; if (ready_M !== 4'b0100) begin miscompares++; $display("FAIL dly_ready: got %b expected 0100", ready_M); end
        vectors++; if (rd_data_M !== 8'hA7) begin miscompares++; $display("FAIL dly_rdata: got %h expected a7", rd_data_M); end
        served = 2;
      end
    end
    vectors++; if (req_cycles !== 6) begin miscompares++; $display("FAIL dly_req_cycles: got %0d expected 6", req_cycles); end
    vectors++; if (rdy_cnt !== 1) begin miscompares++; $display("FAIL dly_ready_count: got %0d expected 1", rdy_cnt); end
  endtask

  // Reset in the middle of BUSY; afterwards core 0 wins first.
  task automatic test_reset_busy();
    do_reset();
    resp_hold = 1'b1;
    set_core(1, 2'b01, 10'h144, 8'h00);
    tick(); tick(); @(negedge clk);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rb_busy: got %b expected 1", mem_req); end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rb_req_drop: got %b expected 0", mem_req); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rb_addr_clear: got %h expected 000", mem_addr); end
    set_core(0, 2'b10, 10'h022, 8'h99);
    resp_hold = 1'b0;
    tick(); tick(); @(negedge clk);
    vectors++; if (ready_M !== '0) begin miscompares++; $display("FAIL rb_no_ready: got %b expected 0000", ready_M); end
    reset = 1'b1;
    tick(); @(negedge clk);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rb_regrant_req: got %b expected 1", mem_req); end
    vectors++; if (mem_addr !== 10'h022) begin miscompares++; $display("FAIL rb_first_core0: got %h expected 022", mem_addr); end
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rb_we: got %b expected 1", mem_we); end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  // TIMEOUT=8: ack on the 8th BUSY cycle wins; no ack aborts after 8 cycles.
  task automatic test_timeout();
    int req_cycles;
    int rdy_cnt;
    int served;
    do_reset();
    resp_delay = 7;
    resp_data  = 8'h5A;
    set_core(3, 2'b01, 10'h30F, 8'h00);
    req_cycles = 0; rdy_cnt = 0; served = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (served >= 0) begin set_core(served, 2'b00, '0, '0); served = -1; end
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (ready_M !== '0) begin
        rdy_cnt++; served = 3;
        vectors++; if (ready_M !== 4'b1000) begin miscompares++; $display("FAIL to_win_ready: got %b expected 1000", ready_M); end
        vectors++; if (rd_data_M !== 8'h5A) begin miscompares++; $display("FAIL to_win_rdata: got %h expected 5a", rd_data_M); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_win_err: got %b expected 0", err); end
      end
    end
    vectors++; if (req_cycles !== 8) begin miscompares++; $display("FAIL to_win_cycles: got %0d expected 8", req_cycles); end
    vectors++; if (rdy_cnt !== 1) begin miscompares++; $display("FAIL to_win_count: got %0d expected 1", rdy_cnt); end

    resp_hold = 1'b1;
    set_core(3, 2'b01, 10'h310, 8'h00);
    req_cycles = 0; rdy_cnt = 0; served = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (served >= 0) begin set_core(served, 2'b00, '0, '0); served = -1; end
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (ready_M !== '0) begin
        rdy_cnt++; served = 3;
        vectors++; if (ready_M !== 4'b1000) begin miscompares++; $display("FAIL to_abort_ready: got %b expected 1000", ready_M); end
        vectors++; if (rd_data_M !== 8'h00) begin miscompares++; $display("FAIL to_abort_rdata: got %h expected 00", rd_data_M); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_abort_err: got %b expected 1", err); end
      end
    end
    vectors++; if (req_cycles !== 8) begin miscompares++; $display("FAIL to_abort_cycles: got %0d expected 8", req_cycles); end
    vectors++; if (rdy_cnt !== 1) begin miscompares++; $display("FAIL to_abort_count: got %0d expected 1", rdy_cnt); end

    resp_hold  = 1'b0;
    resp_delay = 0;
    set_core(1, 2'b10, 10'h1EE, 8'h42);
    repeat (4) tick();
    set_core(1, 2'b00, '0, '0);
    repeat (3) tick();
    @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err_sticky: got %b expected 1", err); end
  endtask
`endif

  // Random cores and random ack latency against a timeline model:
  // an access granted at edge n completes on the edge that samples ack,
  // pulses ready for one cycle, and the next grant decision is two edges later.
  task automatic test_random();
    int last_g;
    int decide_at;
    int acc_g;
    int served;
    bit in_acc;
    bit done;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wd;
    logic [DW-1:0] exp_rd;
    logic [NC-1:0] exp_rdy;
    logic [2*NC-1:0]  s_en;
    logic [AW*NC-1:0] s_ad;
    logic [DW*NC-1:0] s_wd;
    logic             s_ack;
    logic [DW-1:0]    s_rd;
    logic [1:0]       code;
    do_reset();
    resp_rand = 1'b1;
    last_g = NC - 1; decide_at = 1; acc_g = 0; served = -1;
    in_acc = 1'b0; done = 1'b0; exp_rd = '0;
    acc_we = 1'b0; acc_addr = '0; acc_wd = '0;
    for (int n = 1; n <= 800; n++) begin
      s_en = enable_M; s_ad = addr_M; s_wd = wr_data_M; s_ack = mem_ack; s_rd = mem_rdata;
      tick();
      done = 1'b0;
      if (in_acc) begin
        if (s_ack) begin
          in_acc = 1'b0; done = 1'b1;
          if (!acc_we) exp_rd = s_rd;
          decide_at = n + 2;
        end
      end else if (n >= decide_at) begin
        acc_g = -1;
        for (int i = 1; i <= NC; i++) begin
          int c;
          c = (last_g + i) % NC;
          code = s_en[2*c +: 2];
          if (acc_g < 0 && (code == 2'b01 || code == 2'b10)) acc_g = c;
        end
        if (acc_g < 0) begin
          decide_at = n + 1;
          acc_g = 0;
        end else begin
          in_acc   = 1'b1;
          last_g   = acc_g;
          acc_we   = s_en[2*acc_g + 1];
          acc_addr = s_ad[acc_g*AW +: AW];
          acc_wd   = s_wd[acc_g*DW +: DW];
        end
      end
      // Core behaviour: a served core moves on; idle cores start at random.
      if (served >= 0) begin
        set_core(served, 2'($urandom_range(0, 3)), AW'(served*256 + $urandom_range(0, 255)), DW'($urandom));
        served = -1;
      end
      if (done) served = acc_g;
      for (int c = 0; c < NC; c++) begin
        code = enable_M[2*c +: 2];
        if (!(code == 2'b01 || code == 2'b10) && $urandom_range(0, 3) == 0)
          set_core(c, 2'($urandom_range(0, 3)), AW'(c*256 + $urandom_range(0, 255)), DW'($urandom));
      end
      @(negedge clk);
      vectors++; if (mem_req !== in_acc) begin miscompares++; $display("FAIL rnd_req @%0d: got %b expected %b", n, mem_req, in_acc); end
      if (in_acc) begin
        vectors++; if (mem_addr !== acc_addr) begin miscompares++; $display("FAIL rnd_addr @%0d: got %h expected %h", n, mem_addr, acc_addr); end
        vectors++; if (mem_we !== acc_we) begin miscompares++; $display("FAIL rnd_we @%0d: got %b expected %b", n, mem_we, acc_we); end
        vectors++; if (mem_wdata !== acc_wd) begin miscompares++; $display("FAIL rnd_wdata @%0d: got %h expected %h", n, mem_wdata, acc_wd); end
      end
      exp_rdy = done ? (NC'(1) << acc_g) : '0;
      vectors++; if (ready_M !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready @%0d: got %b expected %b", n, ready_M, exp_rdy); end
      vectors++; if (rd_data_M !== exp_rd) begin miscompares++; $display("FAIL rnd_rdata @%0d: got %h expected %h", n, rd_data_M, exp_rd); end
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable_M  = '0;
    addr_M    = '0;
    wr_data_M = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    resp_rand = 1'b0;
    resp_hold = 1'b0;
    resp_busy = 1'b0;
    resp_delay = 0;
    resp_wait = 0;
    resp_data = '0;
    test_reset();
    test_single_load();
    test_all_store();
    test_alternate();
    test_delayed_ack();
    test_reset_busy();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
